fast_score_nms: RTL and testbench

- Downstream stage of the FAST segment-test block.
- Consumes the per-pixel corner flag and the 16 circle absolute differences, and computes an integer corner score (sum of the 16 differences, zero when not a corner).
- Applies 3x3 non-maximum suppression over the score image using two score line buffers.
- Emits a thinned corner flag plus score, with H/V/DE syncs delayed to match.

---
 rtl/fast_score_nms_if.sv | 26 ++
 rtl/fast_score_nms.sv | 125 ++++++++++++
 tb/tb_fast_score_nms.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fast_score_nms_if.sv
// Stream bundle for the FAST score/NMS stage: pixel-aligned syncs and features in,
// delayed syncs plus thinned corner out.
interface fast_score_nms_if;
  // TVALID_in is a pure advance enable: there is no ready, every beat with TVALID_in = 1 is consumed.
  logic         TVALID_in;
  logic         in_H_SYNC;
  logic         in_V_SYNC;
  logic         in_data_en;
  logic         Feature_val;
  logic [127:0] abs_df_bus;
  logic         o_H_SYNC;
  logic         o_V_SYNC;
  logic         o_data_en;
  logic         o_corner;
  logic [11:0]  o_score;

  modport master (
    output TVALID_in, in_H_SYNC, in_V_SYNC, in_data_en, Feature_val, abs_df_bus,
    input  o_H_SYNC, o_V_SYNC, o_data_en, o_corner, o_score
  );

  modport slave (
    input  TVALID_in, in_H_SYNC, in_V_SYNC, in_data_en, Feature_val, abs_df_bus,
    output o_H_SYNC, o_V_SYNC, o_data_en, o_corner, o_score
  );
endinterface

// File: rtl/fast_score_nms.sv
// FAST corner score (sum of 16 circle differences) followed by 3x3 non-maximum
// suppression over the score image using two score line buffers.
module fast_score_nms #(
  parameter int IMG_WIDTH = 640,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  fast_score_nms_if.slave  bus
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic        en;
  logic [8:0]  s1 [8];
  logic [9:0]  s2 [4];
  logic [10:0] s3 [2];
  logic [11:0] s4;
  logic [2:0]  fv_d;
  logic [5:0]  hs_d, vs_d, de_d;

  logic [CNT_W-1:0] col, row;
  logic [CNT_W-1:0] pos_col, pos_row;
  logic [AW-1:0]    addr;

  logic [11:0] lb0 [IMG_WIDTH];
  logic [11:0] lb1 [IMG_WIDTH];
  logic [11:0] lb0_rd, lb1_rd;
  logic [11:0] win [3][3];
  logic [11:0] centre;
  logic        hit;
  logic        corner_q;
  logic [11:0] score_q;

  assign en     = bus.TVALID_in;
  assign addr   = col[AW-1:0];
  assign lb0_rd = lb0[addr];
  assign lb1_rd = lb1[addr];
  assign centre = win[1][1];

  // Earlier raster neighbours must be strictly smaller, later ones may tie.
  always_comb begin
    hit = de_d[4] && (pos_row >= TWO) && (pos_col >= TWO) && (centre != 12'd0)
        && (centre >  win[0][0]) && (centre >  win[0][1]) && (centre >  win[0][2])
        && (centre >  win[1][0])
        && (centre >= win[1][2]) && (centre >= win[2][0]) && (centre >= win[2][1])
        && (centre >= win[2][2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) s1[i] <= '0;
      for (int i = 0; i < 4; i++) s2[i] <= '0;
      for (int i = 0; i < 2; i++) s3[i] <= '0;
      s4       <= '0;
      fv_d     <= '0;
      hs_d     <= '0;
      vs_d     <= '0;
      de_d     <= '0;
      col      <= '0;
      row      <= '0;
      pos_col  <= '0;
      pos_row  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      corner_q <= 1'b0;
      score_q  <= '0;
    end else if (en) begin
      for (int i = 0; i < 8; i++)
        s1[i] <= {1'b0, bus.abs_df_bus[16*i +: 8]} + {1'b0, bus.abs_df_bus[16*i+8 +: 8]};
      for (int i = 0; i < 4; i++) s2[i] <= {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
      for (int i = 0; i < 2; i++) s3[i] <= {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
      s4   <= ({1'b0, s3[0]} + {1'b0, s3[1]}) & {12{fv_d[2]}};
      fv_d <= {fv_d[1:0], bus.Feature_val};
      hs_d <= {hs_d[4:0], bus.in_H_SYNC};
      vs_d <= {vs_d[4:0], bus.in_V_SYNC};
      de_d <= {de_d[4:0], bus.in_data_en};

      if (vs_d[3]) begin
        col <= '0;
        row <= '0;
      end else if (de_d[3]) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row != ROW_MAX) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (de_d[3]) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= s4;
        pos_col   <= col;
        pos_row   <= row;
      end

      corner_q <= hit;
      score_q  <= hit ? centre : 12'd0;
    end
  end

  // Line buffers carry no reset; rows 0/1 of each frame are masked at the output.
  always_ff @(posedge clk) begin
    if (en && de_d[3]) begin
      lb0[addr] <= s4;
      lb1[addr] <= lb0_rd;
    end
  end

  assign bus.o_H_SYNC  = hs_d[5];
  assign bus.o_V_SYNC  = vs_d[5];
  assign bus.o_data_en = de_d[5];
  assign bus.o_corner  = corner_q;
  assign bus.o_score   = score_q;

endmodule

// File: tb/tb_fast_score_nms.sv
// Bench for fast_score_nms on an 8x6 frame: directed score/NMS/border cases plus
// random frames with and without TVALID gaps, checked against a frame-level model.
module tb_fast_score_nms;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fast_score_nms_if bus ();

  fast_score_nms #(.IMG_WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] seq_a[$];
  logic [15:0] last_exp;
  logic        record;
  int          hit_cnt;
  int          hit_sum;

  logic         fv_a [H][W];
  logic [127:0] df_a [H][W];
  int           sc   [H][W];

  function automatic int bus_sum(input logic [127:0] b);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [127:0] make_bus(input int score);
    logic [127:0] b = '0;
    int rem = score;
    for (int i = 0; i < 16; i++) begin
      int v = (rem > 255) ? 255 : rem;
      b[8*i +: 8] = 8'(v);
      rem -= v;
    end
    return b;
  endfunction

  function automatic logic [15:0] pack_obs();
    return {bus.o_H_SYNC, bus.o_V_SYNC, bus.o_data_en, bus.o_corner, bus.o_score};
  endfunction

  // Output tuple for a beat: its own syncs plus the NMS verdict for the pixel one row up, one column left.
  function automatic logic [15:0] ref_out(input logic hs, input logic vs, input logic de,
                                          input int r, input int c);
    logic corner = 1'b0;
    int   cs = 0;
    if (de && r >= 2 && c >= 2) begin
      cs = sc[r-1][c-1];
      corner = (cs != 0)
        && cs >  sc[r-2][c-2] && cs >  sc[r-2][c-1] && cs >  sc[r-2][c]
        && cs >  sc[r-1][c-2]
        && cs >= sc[r-1][c]   && cs >= sc[r][c-2]   && cs >= sc[r][c-1] && cs >= sc[r][c];
    end
    return {hs, vs, de, corner, corner ? 12'(cs) : 12'd0};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_random_inputs();
    bus.in_H_SYNC   = 1'($urandom_range(1));
    bus.in_V_SYNC   = 1'($urandom_range(1));
    bus.in_data_en  = 1'($urandom_range(1));
    bus.Feature_val = 1'($urandom_range(1));
    bus.abs_df_bus  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step(input logic hs, input logic vs, input logic de, input logic fv,
                      input logic [127:0] df, input int r, input int c, input int stall_pct);
    int gaps = 0;
    while (stall_pct > 0 && gaps < 8 && int'($urandom_range(99)) < stall_pct) begin
      @(negedge clk);
      bus.TVALID_in = 1'b0;
      drive_random_inputs();
      @(posedge clk);
      #1 check("hold", int'(pack_obs()), int'(last_exp));
      gaps++;
    end
    @(negedge clk);
    bus.TVALID_in   = 1'b1;
    bus.in_H_SYNC   = hs;
    bus.in_V_SYNC   = vs;
    bus.in_data_en  = de;
    bus.Feature_val = fv;
    bus.abs_df_bus  = df;
    exp_q.push_back(ref_out(hs, vs, de, r, c));
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check("out", int'(pack_obs()), int'(last_exp));
    if (bus.o_corner) begin
      hit_cnt++;
      hit_sum += int'(bus.o_score);
    end
    if (record) obs_q.push_back(pack_obs());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.TVALID_in = 1'b0;
    drive_random_inputs();
    #1 check("reset_out", int'(pack_obs()), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) exp_q.push_back(16'h0);
    last_exp = 16'h0;
  endtask

  task automatic clear_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fv_a[r][c] = 1'b0;
        df_a[r][c] = '0;
      end
  endtask

  task automatic place(input int r, input int c, input int score);
    fv_a[r][c] = 1'b1;
    df_a[r][c] = make_bus(score);
  endtask

  task automatic run_frame(input int nvs, input int stall_pct, input int stop_beats);
    int beats = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) sc[r][c] = fv_a[r][c] ? bus_sum(df_a[r][c]) : 0;
    hit_cnt = 0;
    hit_sum = 0;
    for (int i = 0; i < nvs; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 0, stall_pct);
    for (int r = 0; r < H; r++) begin
      for (int i = 0; i < 2; i++)
        step(1'b1, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, stall_pct);
      for (int c = 0; c < W; c++) begin
        if (stop_beats > 0 && beats >= stop_beats) return;
        step(1'b0, 1'b0, 1'b1, fv_a[r][c], df_a[r][c], r, c, stall_pct);
        beats++;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0, stall_pct);
  endtask

  task automatic random_frame(input int max_byte);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fv_a[r][c] = ($urandom_range(99) < 40);
        for (int i = 0; i < 16; i++) df_a[r][c][8*i +: 8] = 8'($urandom_range(max_byte));
      end
  endtask

  initial begin
    record = 1'b0;
    rst = 1'b1;
    bus.TVALID_in = 1'b0;
    drive_random_inputs();
    #1 check("por_out", int'(pack_obs()), 0);
    do_reset();

    // Reset mid-frame, then a fresh frame without a V_SYNC lead-in relies on counters at 0.
    random_frame(255);
    run_frame(3, 0, 20);
    do_reset();

    clear_frame();
    for (int i = 0; i < 16; i++) df_a[2][3][8*i +: 8] = 8'hff;
    fv_a[2][3] = 1'b1;
    run_frame(0, 0, 0);
    check("iso_hits", hit_cnt, 1);
    check("iso_score", hit_sum, 4080);

    clear_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) df_a[r][c] = {16{8'd200}};
    run_frame(3, 0, 0);
    check("nofeat_hits", hit_cnt, 0);

    clear_frame();
    place(2, 2, 100);
    place(2, 3, 150);
    run_frame(3, 0, 0);
    check("sup_hits", hit_cnt, 1);
    check("sup_score", hit_sum, 150);

    clear_frame();
    place(3, 2, 120);
    place(3, 3, 120);
    run_frame(3, 0, 0);
    check("tie_hits", hit_cnt, 1);
    check("tie_score", hit_sum, 120);

    clear_frame();
    place(0, 3, 4080);
    place(2, 0, 4080);
    place(5, 4, 4080);
    place(3, 7, 4080);
    run_frame(3, 0, 0);
    check("border_hits", hit_cnt, 0);

    // Same random frame with and without enable gaps must give the same per-beat output stream.
    random_frame(255);
    do_reset();
    obs_q.delete();
    record = 1'b1;
    run_frame(3, 0, 0);
    seq_a = obs_q;
    obs_q.delete();
    do_reset();
    run_frame(3, 30, 0);
    record = 1'b0;
    check("stall_len", obs_q.size(), seq_a.size());
    for (int i = 0; i < seq_a.size() && i < obs_q.size(); i++)
      check("stall_seq", int'(obs_q[i]), int'(seq_a[i]));

    // Low-magnitude random scores produce many plateaus, exercising the tie rule.
    for (int f = 0; f < 3; f++) begin
      random_frame(1);
      run_frame(3, 30, 0);
    end
    random_frame(255);
    run_frame(3, 30, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
